memory_stage: RTL and testbench

- MEM stage of the 5-stage MIPS pipeline, directly downstream of the execute stage.
- Consumes the execute-stage result (ALU output, destination register, lw/sw flags, store data).
- Performs lw/sw through a req/ack handshake to data memory, stalling upstream stages while an access is outstanding.
- Registers the results into the MEM/WB pipeline register, which also serves as the forwarding source.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/mem_handshake_fsm.sv | 115 +++++++++++
 rtl/memory_stage.sv | 119 +++++++++++
 tb/tb_memory_stage.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline memory stage.
// Holds the handshake FSM state encoding, default bus widths, the zero-register
// index and a word-alignment helper.
package mips_pkg;

  localparam int unsigned DW_DEF      = 32;
  localparam int unsigned RW_DEF      = 5;
  localparam int unsigned TIMEOUT_DEF = 16;

  localparam logic [RW_DEF-1:0] ZERO_REG = '0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_e;

  // Byte address is usable for a word access only when its two LSBs are zero
  function automatic logic word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/mem_handshake_fsm.sv
// Data-memory req/ack handshake for the MEM stage.
// Latches the access (addr/we/wdata/rd) on start, holds dmem_req until ack.
// Optional MEM_TIMEOUT_EN: aborts an access after TIMEOUT_CYCLES BUSY cycles.
// Ports:
//   clk, rst           clock, async active-low reset
//   start              launch an access (only honoured in IDLE)
//   start_we/addr/wdata/rd  access to latch
//   dmem_ack           access complete pulse
//   dmem_req/we/addr/wdata  registered memory request
//   lat_rd             latched destination register
//   busy_c             FSM in BUSY
//   done_c             ack seen while BUSY
//   abort_c            timeout abort in this cycle (0 without MEM_TIMEOUT_EN)
module mem_handshake_fsm
  import mips_pkg::*;
#(
  parameter int unsigned DW             = DW_DEF,
  parameter int unsigned RW             = RW_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          start_we,
  input  logic [DW-1:0] start_addr,
  input  logic [DW-1:0] start_wdata,
  input  logic [RW-1:0] start_rd,
  input  logic          dmem_ack,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  output logic [RW-1:0] lat_rd,
  output logic          busy_c,
  output logic          done_c,
  output logic          abort_c
);

  mem_state_e    state, state_nxt;
  logic          req_nxt, we_nxt;
  logic [DW-1:0] addr_nxt, wdata_nxt;
  logic [RW-1:0] rd_nxt;

  assign busy_c = (state == ST_BUSY);
  assign done_c = busy_c & dmem_ack;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] cnt, cnt_nxt;

  // An ack in the final cycle wins over the abort
  assign abort_c = busy_c & ~dmem_ack & (cnt == CW'(TIMEOUT_CYCLES - 1));

  // Cleared whenever not waiting, so every BUSY entry starts from zero
  always_comb cnt_nxt = (busy_c & ~dmem_ack) ? cnt + CW'(1) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else      cnt <= cnt_nxt;
  end
`else
  logic unused_cfg;
  assign unused_cfg = |TIMEOUT_CYCLES;
  assign abort_c    = 1'b0;
`endif

  // Next-state and request latch
  always_comb begin
    state_nxt = state;
    req_nxt   = dmem_req;
    we_nxt    = dmem_we;
    addr_nxt  = dmem_addr;
    wdata_nxt = dmem_wdata;
    rd_nxt    = lat_rd;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_BUSY;
          req_nxt   = 1'b1;
          we_nxt    = start_we;
          addr_nxt  = start_addr;
          wdata_nxt = start_wdata;
          rd_nxt    = start_rd;
        end
      end
      ST_BUSY: begin
        if (done_c | abort_c) begin
          state_nxt = ST_IDLE;
          req_nxt   = 1'b0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      lat_rd     <= '0;
    end else begin
      state      <= state_nxt;
      dmem_req   <= req_nxt;
      dmem_we    <= we_nxt;
      dmem_addr  <= addr_nxt;
      dmem_wdata <= wdata_nxt;
      lat_rd     <= rd_nxt;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// MEM stage of the 5-stage MIPS pipeline.
// Passes ALU results to the MEM/WB register, runs lw/sw through a req/ack
// data-memory handshake (stalling upstream while outstanding) and flags
// misaligned accesses. MEM/WB register doubles as the forwarding source.
// Optional macro MEM_TIMEOUT_EN enables the access-abort timeout.
// Ports:
//   clk, rst                    clock, async active-low reset
//   ALUout, XM_*                execute-stage result and control
//   dmem_req/we/addr/wdata      memory request (registered)
//   dmem_rdata, dmem_ack        memory response
//   stall                       hold IF/ID/EX (combinational)
//   MW_RD, MW_data, MW_regWrite writeback / forwarding register
//   misalign_err, timeout_err   one-cycle error pulses
module memory_stage
  import mips_pkg::*;
#(
  parameter int unsigned DW             = DW_DEF,
  parameter int unsigned RW             = RW_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] ALUout,
  input  logic [RW-1:0] XM_RD,
  input  logic          XM_lwFlag,
  input  logic          XM_swFlag,
  input  logic [DW-1:0] XM_storeData,
  input  logic          XM_regWriteEn,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_ack,
  output logic          stall,
  output logic [RW-1:0] MW_RD,
  output logic [DW-1:0] MW_data,
  output logic          MW_regWrite,
  output logic          misalign_err,
  output logic          timeout_err
);

  logic          busy_c, done_c, abort_c;
  logic          is_mem_c, aligned_c, mem_op_c, misalign_c;
  logic [RW-1:0] lat_rd;
  logic [DW-1:0] mw_data_nxt;
  logic [RW-1:0] mw_rd_nxt;
  logic          mw_we_nxt, mis_nxt, to_nxt;

  assign is_mem_c   = XM_lwFlag | XM_swFlag;
  assign aligned_c  = word_aligned(ALUout[1:0]);
  assign mem_op_c   = ~busy_c & is_mem_c & aligned_c;
  assign misalign_c = ~busy_c & is_mem_c & ~aligned_c;

  // Upstream is released in the ack/abort cycle; forced low while in reset
  assign stall = rst & (mem_op_c | (busy_c & ~done_c & ~abort_c));

  mem_handshake_fsm #(
    .DW             (DW),
    .RW             (RW),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_hs (
    .clk         (clk),
    .rst         (rst),
    .start       (mem_op_c),
    .start_we    (XM_swFlag & ~XM_lwFlag),
    .start_addr  (ALUout),
    .start_wdata (XM_storeData),
    .start_rd    (XM_RD),
    .dmem_ack    (dmem_ack),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .lat_rd      (lat_rd),
    .busy_c      (busy_c),
    .done_c      (done_c),
    .abort_c     (abort_c)
  );

  // MEM/WB next values; anything other than a retiring ALU op or load is a bubble
  always_comb begin
    mw_data_nxt = MW_data;
    mw_rd_nxt   = MW_RD;
    mw_we_nxt   = 1'b0;
    mis_nxt     = 1'b0;
    to_nxt      = abort_c;
    if (busy_c) begin
      if (done_c && !dmem_we) begin
        mw_data_nxt = dmem_rdata;
        mw_rd_nxt   = lat_rd;
        mw_we_nxt   = (lat_rd != RW'(ZERO_REG));
      end
    end else if (misalign_c) begin
      mis_nxt = 1'b1;
    end else if (!is_mem_c) begin
      mw_data_nxt = ALUout;
      mw_rd_nxt   = XM_RD;
      mw_we_nxt   = XM_regWriteEn & (XM_RD != RW'(ZERO_REG));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MW_data      <= '0;
      MW_RD        <= '0;
      MW_regWrite  <= 1'b0;
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      MW_data      <= mw_data_nxt;
      MW_RD        <= mw_rd_nxt;
      MW_regWrite  <= mw_we_nxt;
      misalign_err <= mis_nxt;
      timeout_err  <= to_nxt;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Randomized self-checking bench for memory_stage. Instructions are issued as
// whole transactions; expectations come from a word-addressed memory model.
module tb_memory_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] ALUout;
  logic [RW-1:0] XM_RD;
  logic          XM_lwFlag, XM_swFlag, XM_regWriteEn;
  logic [DW-1:0] XM_storeData;
  logic          dmem_req, dmem_we;
  logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic          dmem_ack;
  logic          stall;
  logic [RW-1:0] MW_RD;
  logic [DW-1:0] MW_data;
  logic          MW_regWrite, misalign_err, timeout_err;

  int total = 0;
  int bad   = 0;

  logic [31:0] ref_mem  [64];
  logic [31:0] resp_mem [64];

  always #5 clk = ~clk;

  memory_stage #(.DW(DW), .RW(RW), .TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .ALUout        (ALUout),
    .XM_RD         (XM_RD),
    .XM_lwFlag     (XM_lwFlag),
    .XM_swFlag     (XM_swFlag),
    .XM_storeData  (XM_storeData),
    .XM_regWriteEn (XM_regWriteEn),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_rdata    (dmem_rdata),
    .dmem_ack      (dmem_ack),
    .stall         (stall),
    .MW_RD         (MW_RD),
    .MW_data       (MW_data),
    .MW_regWrite   (MW_regWrite),
    .misalign_err  (misalign_err),
    .timeout_err   (timeout_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit lw, input bit sw, input logic [4:0] rd, input bit en,
                       input logic [31:0] alu, input logic [31:0] sdata);
    XM_lwFlag     = lw;
    XM_swFlag     = sw;
    XM_RD         = rd;
    XM_regWriteEn = en;
    ALUout        = alu;
    XM_storeData  = sdata;
  endtask

  // Issue one instruction starting just after a posedge; returns just after a posedge.
  // dly = BUSY cycles without ack before the ack cycle.
  task automatic run_instr(input bit lw, input bit sw, input logic [4:0] rd, input bit en,
                           input logic [31:0] alu, input logic [31:0] sdata,
                           input int dly, input bit stray);
    int idx;
    bit is_ld;
    idx   = int'(alu[7:2]);
    is_ld = lw;
    drive(lw, sw, rd, en, alu, sdata);
    if (!(lw || sw)) begin
      dmem_ack = stray;
      @(negedge clk);
      check_eq("alu_stall", stall, 0);
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      check_eq("alu_data", MW_data, alu);
      check_eq("alu_rd", MW_RD, rd);
      check_eq("alu_we", MW_regWrite, 32'(en && rd != 0));
      check_eq("alu_req", dmem_req, 0);
      check_eq("alu_mis", misalign_err, 0);
      check_eq("alu_to", timeout_err, 0);
    end else if (alu[1:0] != 2'b00) begin
      @(negedge clk);
      check_eq("mis_stall", stall, 0);
      check_eq("mis_req0", dmem_req, 0);
      @(posedge clk); #1;
      check_eq("mis_err", misalign_err, 1);
      check_eq("mis_we", MW_regWrite, 0);
      check_eq("mis_req1", dmem_req, 0);
    end else begin
      @(negedge clk);
      check_eq("req_stall", stall, 1);
      check_eq("req_pre", dmem_req, 0);
      @(posedge clk); #1;
      check_eq("req_on", dmem_req, 1);
      check_eq("req_addr", dmem_addr, alu);
      check_eq("req_dir", dmem_we, 32'(!is_ld));
      if (!is_ld) check_eq("req_wdata", dmem_wdata, sdata);
      check_eq("req_bubble", MW_regWrite, 0);
      for (int c = 0; c < dly; c++) begin
        @(negedge clk);
        check_eq("wait_stall", stall, 1);
        check_eq("wait_req", dmem_req, 1);
        check_eq("wait_addr", dmem_addr, alu);
        @(posedge clk); #1;
        check_eq("wait_bubble", MW_regWrite, 0);
        check_eq("wait_to", timeout_err, 0);
      end
      dmem_ack   = 1'b1;
      dmem_rdata = is_ld ? resp_mem[idx] : $urandom;
      @(negedge clk);
      check_eq("ack_stall", stall, 0);
      if (dmem_we) resp_mem[dmem_addr[7:2]] = dmem_wdata;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      check_eq("ack_req", dmem_req, 0);
      check_eq("ack_to", timeout_err, 0);
      if (is_ld) begin
        check_eq("ld_data", MW_data, ref_mem[idx]);
        check_eq("ld_rd", MW_RD, rd);
        check_eq("ld_we", MW_regWrite, 32'(rd != 0));
      end else begin
        check_eq("st_we", MW_regWrite, 0);
        ref_mem[idx] = sdata;
      end
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  // Load that either never gets an ack or gets it in the last allowed cycle
  task automatic run_timeout(input bit ack_last, input logic [4:0] rd, input logic [31:0] alu);
    int idx;
    idx = int'(alu[7:2]);
    drive(1'b1, 1'b0, rd, 1'b1, alu, 32'h0);
    @(negedge clk);
    check_eq("to_stall0", stall, 1);
    @(posedge clk); #1;
    check_eq("to_req", dmem_req, 1);
    for (int c = 0; c < int'(TO) - 1; c++) begin
      @(negedge clk);
      check_eq("to_stall", stall, 1);
      @(posedge clk); #1;
      check_eq("to_early", timeout_err, 0);
      check_eq("to_held", dmem_req, 1);
    end
    dmem_ack   = ack_last;
    dmem_rdata = resp_mem[idx];
    @(negedge clk);
    check_eq("to_last_stall", stall, 0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    check_eq("to_req_off", dmem_req, 0);
    check_eq("to_err", timeout_err, 32'(!ack_last));
    check_eq("to_we", MW_regWrite, 32'(ack_last && rd != 0));
    if (ack_last) check_eq("to_data", MW_data, ref_mem[idx]);
  endtask
`endif

  initial begin
    logic [31:0] a;
    int kind;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i]  = $urandom;
      resp_mem[i] = ref_mem[i];
    end
    rst        = 1'b0;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    drive(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    #1;
    check_eq("rst_req", dmem_req, 0);
    check_eq("rst_we", dmem_we, 0);
    check_eq("rst_addr", dmem_addr, 0);
    check_eq("rst_wdata", dmem_wdata, 0);
    check_eq("rst_mwdata", MW_data, 0);
    check_eq("rst_mwrd", MW_RD, 0);
    check_eq("rst_mwwe", MW_regWrite, 0);
    check_eq("rst_mis", misalign_err, 0);
    check_eq("rst_to", timeout_err, 0);
    check_eq("rst_stall", stall, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_instr(1'b0, 1'b0, 5'd5, 1'b1, 32'h1234, 32'h0, 0, 1'b0);
    ref_mem[16]  = 32'hDEADBEEF;
    resp_mem[16] = 32'hDEADBEEF;
    run_instr(1'b1, 1'b0, 5'd7, 1'b1, 32'h40, 32'h0, 3, 1'b0);
    run_instr(1'b0, 1'b1, 5'd3, 1'b0, 32'h8, 32'hA5A5, 1, 1'b0);
    run_instr(1'b1, 1'b0, 5'd9, 1'b1, 32'h8, 32'h0, 0, 1'b0);
    run_instr(1'b1, 1'b0, 5'd4, 1'b1, 32'h42, 32'h0, 0, 1'b0);
    run_instr(1'b0, 1'b0, 5'd0, 1'b1, 32'hFFFF0000, 32'h0, 0, 1'b1);
    run_instr(1'b1, 1'b0, 5'd0, 1'b1, 32'h40, 32'h0, 2, 1'b0);

`ifdef MEM_TIMEOUT_EN
    run_timeout(1'b0, 5'd6, 32'h20);
    run_instr(1'b0, 1'b0, 5'd1, 1'b1, 32'h55, 32'h0, 0, 1'b0);
    run_timeout(1'b1, 5'd6, 32'h20);
    run_instr(1'b0, 1'b0, 5'd1, 1'b1, 32'h66, 32'h0, 0, 1'b0);
`else
    // Without the timeout a long wait must still complete normally
    run_instr(1'b1, 1'b0, 5'd2, 1'b1, 32'h20, 32'h0, 20, 1'b0);
`endif

    // Random instruction stream
    for (int n = 0; n < 200; n++) begin
      kind = int'($urandom_range(0, 9));
      a    = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      case (kind)
        0, 1, 2, 3:
          run_instr(1'b0, 1'b0, 5'($urandom), 1'($urandom), $urandom, $urandom,
                    0, 1'($urandom));
        4, 5:
          run_instr(1'b1, 1'b0, 5'($urandom), 1'($urandom), a, $urandom,
                    int'($urandom_range(0, 3)), 1'b0);
        6, 7:
          run_instr(1'b0, 1'b1, 5'($urandom), 1'($urandom), a, $urandom,
                    int'($urandom_range(0, 3)), 1'b0);
        8:
          run_instr(1'b1, 1'b1, 5'($urandom), 1'($urandom), a, $urandom,
                    int'($urandom_range(0, 3)), 1'b0);
        default:
          run_instr(1'($urandom), 1'b1, 5'($urandom), 1'b1,
                    a | 32'($urandom_range(1, 3)), $urandom, 0, 1'b0);
      endcase
    end

    // Reset in the middle of an outstanding access
    drive(1'b1, 1'b0, 5'd8, 1'b1, 32'h40, 32'h0);
    @(negedge clk);
    @(posedge clk); #1;
    check_eq("mid_req", dmem_req, 1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("mid_rst_req", dmem_req, 0);
    check_eq("mid_rst_data", MW_data, 0);
    check_eq("mid_rst_rd", MW_RD, 0);
    check_eq("mid_rst_we", MW_regWrite, 0);
    check_eq("mid_rst_stall", stall, 0);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_req", dmem_req, 0);
    run_instr(1'b0, 1'b0, 5'd12, 1'b1, 32'hCAFE, 32'h0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
